boot_uart_rx: RTL

Serial receiver for the boot-load path: recovers 8N1 UART frames from the asynchronous `rx` pin and delivers each received character as a one-cycle `out_valid` pulse with `out_char`. It sits directly upstream of the boot hex parser, and its `out_valid`/`out_char` connect straight to the parser's `in_valid`/`in_char`. Framing errors are flagged separately, and the offending character is never forwarded.

---
 rtl/boot_uart_rx_pkg.sv | 23 ++
 rtl/boot_uart_rx_sync2.sv | 32 +++
 rtl/boot_uart_rx.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/boot_uart_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : boot_pkg
// Brief    : Shared types and helpers for the boot-load UART path.
// Revision : 1.0
// ============================================================================
package boot_pkg;

  typedef enum logic [2:0] {
    RX_IDLE      = 3'd0,
    RX_START     = 3'd1,
    RX_DATA      = 3'd2,
    RX_STOP      = 3'd3,
    RX_WAIT_HIGH = 3'd4
  } rx_state_t;

  // Clocks per bit rounded to nearest; exact ties only arise with an even baud, so they round up.
  function automatic int uart_cpb(input longint clk_hz, input longint baud);
    return int'((2 * clk_hz + baud) / (2 * baud));
  endfunction

endpackage
`default_nettype wire

// File: rtl/boot_uart_rx_sync2.sv
`default_nettype none
// ============================================================================
// Module   : boot_sync2
// Brief    : Two-flop synchronizer for asynchronous boot inputs.
// Revision : 1.0
// ============================================================================
module boot_sync2 #(
  parameter logic RESET_VALUE = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_meta <= RESET_VALUE;
      r_sync <= RESET_VALUE;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/boot_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : boot_uart_rx
// Brief    : 8N1 UART receiver feeding the boot hex parser; flags framing errors.
// Revision : 1.0
// ============================================================================
module boot_uart_rx
  import boot_pkg::*;
#(
  parameter int clk_frequency = 12_500_000,
  parameter int baud_rate     = 115_200,
  parameter int char_width    = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx,
  output logic                  out_valid,
  output logic [char_width-1:0] out_char,
  output logic                  framing_error,
  output logic                  active
);

  localparam int CPB   = uart_cpb(clk_frequency, baud_rate);
  localparam int HALF  = CPB / 2;
  localparam int CNT_W = $clog2(CPB + 1);
  localparam int IDX_W = $clog2(char_width + 1);

  localparam logic [CNT_W-1:0] C_HALF_M1  = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] C_CPB_M1   = CNT_W'(CPB - 1);
  localparam logic [IDX_W-1:0] C_IDX_LAST = IDX_W'(char_width - 1);

  generate
    if (CPB < 4) begin : g_cpb_check
      $error("boot_uart_rx: clocks per bit must be at least 4");
    end
  endgenerate

  logic                  w_rx_s;
  logic                  w_sample;
  rx_state_t             r_state,    w_state_nxt;
  logic [CNT_W-1:0]      r_cnt,      w_cnt_nxt;
  logic [IDX_W-1:0]      r_idx,      w_idx_nxt;
  logic [char_width-1:0] r_shift,    w_shift_nxt;
  logic [char_width-1:0] r_out_char, w_out_char_nxt;
  logic                  r_valid,    w_valid_nxt;
  logic                  r_fe,       w_fe_nxt;

  boot_sync2 #(
    .RESET_VALUE (1'b1)
  ) u_rx_sync (
    .clk   (clk),
    .reset (reset),
    .i_d   (rx),
    .o_q   (w_rx_s)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= RX_IDLE;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_shift    <= '0;
      r_out_char <= '0;
      r_valid    <= 1'b0;
      r_fe       <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_idx      <= w_idx_nxt;
      r_shift    <= w_shift_nxt;
      r_out_char <= w_out_char_nxt;
      r_valid    <= w_valid_nxt;
      r_fe       <= w_fe_nxt;
    end
  end

  assign w_sample = (r_cnt == '0);

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_idx_nxt      = r_idx;
    w_shift_nxt    = r_shift;
    w_out_char_nxt = r_out_char;
    w_valid_nxt    = 1'b0;
    w_fe_nxt       = 1'b0;

    // One counter paces every bit-timed state; IDLE and WAIT_HIGH just hold it.
    if (r_state == RX_START || r_state == RX_DATA || r_state == RX_STOP) begin
      w_cnt_nxt = w_sample ? C_CPB_M1 : r_cnt - CNT_W'(1);
    end

    case (r_state)
      RX_IDLE: begin
        if (!w_rx_s) begin
          w_state_nxt = RX_START;
          w_cnt_nxt   = C_HALF_M1;
        end
      end
      RX_START: begin
        if (w_sample) begin
          if (!w_rx_s) begin
            w_state_nxt = RX_DATA;
            w_idx_nxt   = '0;
          end else begin
            w_state_nxt = RX_IDLE;
          end
        end
      end
      RX_DATA: begin
        if (w_sample) begin
          w_shift_nxt = {w_rx_s, r_shift[char_width-1:1]};
          if (r_idx == C_IDX_LAST) begin
            w_state_nxt = RX_STOP;
          end else begin
            w_idx_nxt = r_idx + IDX_W'(1);
          end
        end
      end
      RX_STOP: begin
        if (w_sample) begin
          if (w_rx_s) begin
            w_out_char_nxt = r_shift;
            w_valid_nxt    = 1'b1;
            w_state_nxt    = RX_IDLE;
          end else begin
            w_fe_nxt    = 1'b1;
            w_state_nxt = RX_WAIT_HIGH;
          end
        end
      end
      RX_WAIT_HIGH: begin
        // A held-low line (break) must not be decoded as a stream of 0x00.
        if (w_rx_s) begin
          w_state_nxt = RX_IDLE;
        end
      end
      default: begin
        w_state_nxt = RX_IDLE;
      end
    endcase
  end

  assign out_valid     = r_valid;
  assign out_char      = r_out_char;
  assign framing_error = r_fe;
  assign active        = (r_state != RX_IDLE);

endmodule
`default_nettype wire
